// File: rtl/mdu_multicycle_pkg.sv
// Shared MDU definitions: op encodings, FSM states and op-class decode helpers.
package mdu_multicycle_pkg;

   typedef enum logic [3:0] {
      OP_MULT  = 4'h0,
      OP_MULTU = 4'h1,
      OP_DIV   = 4'h2,
      OP_DIVU  = 4'h3,
      OP_MADD  = 4'h4,
      OP_MADDU = 4'h5,
      OP_MSUB  = 4'h6,
      OP_MSUBU = 4'h7
   } mdu_op_e;

   typedef enum logic {
      ST_IDLE,
      ST_RUN
   } mdu_state_e;

   function automatic logic op_is_div(input logic [3:0] op);
      return (op == OP_DIV) || (op == OP_DIVU);
   endfunction

   // Only the low eight codes are defined; anything else issues as a no-op.
   function automatic logic op_is_valid(input logic [3:0] op);
      return op[3] == 1'b0;
   endfunction

endpackage

// File: rtl/mdu_if.sv
// E-stage to MDU interface: issue/MT* controls from the pipeline, busy/HI/LO back.
interface mdu_if #(
   parameter int DATA_W = 32
);
   logic              req;
   logic              start;
   logic [3:0]        op;
   logic [DATA_W-1:0] rs;
   logic [DATA_W-1:0] rt;
   logic              wr_hi;
   logic              wr_lo;
   logic              busy;
   logic [DATA_W-1:0] hi;
   logic [DATA_W-1:0] lo;

   modport master (
      output req, start, op, rs, rt, wr_hi, wr_lo,
      input  busy, hi, lo
   );

   modport slave (
      input  req, start, op, rs, rt, wr_hi, wr_lo,
      output busy, hi, lo
   );
endinterface

// File: rtl/mdu_multicycle_latency_ctr.sv
// Loadable down-counter modelling MDU latency; done flags the last busy cycle.
module mdu_latency_ctr #(
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [CNT_W-1:0] value,
   input  logic             tick,
   output logic             done,
   output logic             active
);

   logic [CNT_W-1:0] count_q;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset)
         count_q <= '0;
      else if (load)
         count_q <= value;
      else if (tick && (count_q != '0))
         count_q <= count_q - CNT_W'(1);
   end

   assign active = (count_q != '0);
   assign done   = tick && (count_q == CNT_W'(1));

endmodule

// File: rtl/mdu_multicycle.sv
// Multi-cycle multiply/divide unit owning HI/LO; results commit atomically after the
// op latency, with busy held throughout for the hazard unit.
module mdu_multicycle
   import mdu_multicycle_pkg::*;
#(
   parameter int DATA_W      = 32,
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10,
   parameter int CNT_W       = $clog2((MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES) + 1)
) (
   input logic   clk,
   input logic   reset,
   mdu_if.slave  bus
);

   localparam int W2 = 2 * DATA_W;

   mdu_state_e        state_q, state_d;
   logic [DATA_W-1:0] hi_q, lo_q;
   logic [W2-1:0]     pend_q;
   logic              pend_we_q;

   logic              busy, issue, mt_ok;
   logic              load, commit;
   logic              ctr_done, ctr_active;
   logic [CNT_W-1:0]  ctr_value;

   logic [W2-1:0]     acc, a_s, b_s, a_u, b_u, prod_s, prod_u;
   logic              div_zero, div_ovf;
   logic signed [DATA_W-1:0] s_rs, s_div;
   logic [DATA_W-1:0] u_div, sq, sr, uq, ur;
   logic [W2-1:0]     result;
   logic              result_we;

   assign busy  = (state_q == ST_RUN);
   assign issue = bus.start && !busy && !bus.req && !reset && op_is_valid(bus.op);
   assign mt_ok = !busy && !bus.req && !bus.start && !reset;

   // NOTE: every combinational output gets a default first, so no path can infer a latch.
   always_comb begin
      acc    = {hi_q, lo_q};
      a_s    = {{DATA_W{bus.rs[DATA_W-1]}}, bus.rs};
      b_s    = {{DATA_W{bus.rt[DATA_W-1]}}, bus.rt};
      a_u    = {{DATA_W{1'b0}}, bus.rs};
      b_u    = {{DATA_W{1'b0}}, bus.rt};
      prod_s = a_s * b_s;
      prod_u = a_u * b_u;

      // MIN / -1 is steered to divide-by-one, which yields exactly lo=MIN, hi=0
      // and keeps the divider away from the overflow case; zero divisors likewise.
      div_zero = (bus.rt == '0);
      div_ovf  = (bus.rs == {1'b1, {(DATA_W-1){1'b0}}}) && (bus.rt == '1);
      s_rs     = bus.rs;
      s_div    = (div_zero || div_ovf) ? DATA_W'(1) : bus.rt;
      u_div    = div_zero ? DATA_W'(1) : bus.rt;
      sq       = s_rs / s_div;
      sr       = s_rs % s_div;
      uq       = bus.rs / u_div;
      ur       = bus.rs % u_div;

      result    = '0;
      result_we = !(op_is_div(bus.op) && div_zero);
      case (mdu_op_e'(bus.op))
         OP_MULT:  result = prod_s;
         OP_MULTU: result = prod_u;
         OP_MADD:  result = acc + prod_s;
         OP_MADDU: result = acc + prod_u;
         OP_MSUB:  result = acc - prod_s;
         OP_MSUBU: result = acc - prod_u;
         OP_DIV:   result = {sr, sq};
         OP_DIVU:  result = {ur, uq};
         default:  result_we = 1'b0;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      load      = 1'b0;
      commit    = 1'b0;
      ctr_value = op_is_div(bus.op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
      case (state_q)
         ST_IDLE: if (issue) begin
            state_d = ST_RUN;
            load    = 1'b1;
         end
         ST_RUN: if (ctr_done) begin
            state_d = ST_IDLE;
            commit  = 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   mdu_latency_ctr #(.CNT_W(CNT_W)) u_ctr (
      .clk    (clk),
      .reset  (reset),
      .load   (load),
      .value  (ctr_value),
      .tick   (busy),
      .done   (ctr_done),
      .active (ctr_active)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         hi_q      <= '0;
         lo_q      <= '0;
         pend_q    <= '0;
         pend_we_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (load) begin
            pend_q    <= result;
            pend_we_q <= result_we;
         end
         if (commit && pend_we_q) begin
            hi_q <= pend_q[W2-1:DATA_W];
            lo_q <= pend_q[DATA_W-1:0];
         end else if (mt_ok) begin
            if (bus.wr_hi) hi_q <= bus.rs;
            if (bus.wr_lo) lo_q <= bus.rs;
         end
      end
   end

   assign bus.busy = busy;
   assign bus.hi   = hi_q;
   assign bus.lo   = lo_q;

   a_no_issue_while_busy: assert property (@(posedge clk) disable iff (reset)
      busy |-> !(bus.start || bus.wr_hi || bus.wr_lo));

   a_ctr_tracks_fsm: assert property (@(posedge clk) disable iff (reset)
      ctr_active == busy);

endmodule

// File: tb/tb_mdu_multicycle.sv
// Directed bench for mdu_multicycle: vector table on a 32-bit unit plus hand-written
// sequences for req, reset abort, start/MT* priority and a 16-bit/1-cycle build.
module tb_mdu_multicycle;
   import mdu_multicycle_pkg::*;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   mdu_if #(.DATA_W(32)) b32 ();
   mdu_if #(.DATA_W(16)) b16 ();

   mdu_multicycle #(.DATA_W(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut32 (
      .clk (clk), .reset (reset), .bus (b32.slave));

   mdu_multicycle #(.DATA_W(16), .MULT_CYCLES(1), .DIV_CYCLES(10)) dut16 (
      .clk (clk), .reset (reset), .bus (b16.slave));

   typedef struct {
      logic [3:0]  op;
      logic [31:0] rs, rt;
      logic [31:0] pre_hi, pre_lo;
      int          cycles;
      logic [31:0] exp_hi, exp_lo;
   } vec_t;

   int n_vec  = 0;
   int n_miss = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic mt32(input logic [31:0] h, input logic [31:0] l);
      @(negedge clk); b32.rs = h; b32.wr_hi = 1'b1;
      @(negedge clk); b32.wr_hi = 1'b0; b32.rs = l; b32.wr_lo = 1'b1;
      @(negedge clk); b32.wr_lo = 1'b0;
   endtask

   // Called one cycle after issue; counts busy cycles with a hard bound.
   task automatic wait_idle32(output int cyc);
      cyc = 0;
      while (b32.busy && cyc < 200) begin
         cyc++;
         @(negedge clk);
      end
   endtask

   task automatic run32(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int cyc);
      @(negedge clk); b32.start = 1'b1; b32.op = op; b32.rs = a; b32.rt = b;
      @(negedge clk); b32.start = 1'b0;
      wait_idle32(cyc);
   endtask

   vec_t vecs[14];

   initial begin
      int cyc;

      vecs[0]  = '{OP_MULT,  32'hFFFFFFFD, 32'h7,        32'h0, 32'h0, 5,  32'hFFFFFFFF, 32'hFFFFFFEB};
      vecs[1]  = '{OP_DIV,   32'hFFFFFFF9, 32'h2,        32'h0, 32'h0, 10, 32'hFFFFFFFF, 32'hFFFFFFFD};
      vecs[2]  = '{OP_DIVU,  32'h7,        32'h0,        32'hFFFFFFFF, 32'hFFFFFFFD, 10, 32'hFFFFFFFF, 32'hFFFFFFFD};
      vecs[3]  = '{OP_MADDU, 32'h2,        32'h3,        32'h5, 32'h6, 5,  32'h5, 32'hC};
      vecs[4]  = '{OP_MSUB,  32'h1,        32'hD,        32'h5, 32'hC, 5,  32'h4, 32'hFFFFFFFF};
      vecs[5]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0, 5,  32'hFFFFFFFE, 32'h1};
      vecs[6]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h1, 32'h1, 10, 32'h0, 32'h80000000};
      vecs[7]  = '{OP_DIV,   32'h7,        32'hFFFFFFFE, 32'h0, 32'h0, 10, 32'h1, 32'hFFFFFFFD};
      vecs[8]  = '{OP_MADD,  32'hFFFFFFFE, 32'h3,        32'h0, 32'h0, 5,  32'hFFFFFFFF, 32'hFFFFFFFA};
      vecs[9]  = '{OP_MSUBU, 32'h1,        32'h1,        32'h0, 32'h0, 5,  32'hFFFFFFFF, 32'hFFFFFFFF};
      vecs[10] = '{4'hF,     32'h3,        32'h3,        32'h11, 32'h22, 0, 32'h11, 32'h22};
      vecs[11] = '{OP_DIVU,  32'hFFFFFFFF, 32'h10,       32'h0, 32'h0, 10, 32'hF, 32'h0FFFFFFF};
      vecs[12] = '{OP_MULTU, 32'h10000,    32'h10000,    32'h0, 32'h0, 5,  32'h1, 32'h0};
      vecs[13] = '{OP_MADD,  32'h1,        32'h1,        32'hFFFFFFFF, 32'hFFFFFFFF, 5, 32'h0, 32'h0};

      {b32.req, b32.start, b32.wr_hi, b32.wr_lo} = '0;
      {b16.req, b16.start, b16.wr_hi, b16.wr_lo} = '0;
      b32.op = '0; b32.rs = '0; b32.rt = '0;
      b16.op = '0; b16.rs = '0; b16.rt = '0;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;

      check("reset_busy", 64'(b32.busy), 64'(0));
      check("reset_hilo", {b32.hi, b32.lo}, 64'h0);

      foreach (vecs[i]) begin
         mt32(vecs[i].pre_hi, vecs[i].pre_lo);
         run32(vecs[i].op, vecs[i].rs, vecs[i].rt, cyc);
         check($sformatf("vec%0d_cycles", i), 64'(cyc), 64'(vecs[i].cycles));
         check($sformatf("vec%0d_hi", i), 64'(b32.hi), 64'(vecs[i].exp_hi));
         check($sformatf("vec%0d_lo", i), 64'(b32.lo), 64'(vecs[i].exp_lo));
      end

      // req squashes both issue and MT* in the same cycle.
      mt32(32'h1, 32'h2);
      @(negedge clk); b32.req = 1'b1; b32.start = 1'b1; b32.op = OP_MULT; b32.rs = 3; b32.rt = 3;
      @(negedge clk); b32.start = 1'b0;
      check("req_start_busy", 64'(b32.busy), 64'(0));
      b32.wr_hi = 1'b1; b32.wr_lo = 1'b1; b32.rs = 32'h99;
      @(negedge clk); b32.wr_hi = 1'b0; b32.wr_lo = 1'b0; b32.req = 1'b0;
      check("req_hilo_kept", {b32.hi, b32.lo}, {32'h1, 32'h2});

      // req arriving while an op is already running must not cancel it.
      @(negedge clk); b32.start = 1'b1; b32.op = OP_MULT; b32.rs = 3; b32.rt = 4;
      @(negedge clk); b32.start = 1'b0; b32.req = 1'b1;
      wait_idle32(cyc);
      b32.req = 1'b0;
      check("req_run_cycles", 64'(cyc), 64'(5));
      check("req_run_hilo", {b32.hi, b32.lo}, {32'h0, 32'hC});

      // start and MTHI together: start wins, HI is not overwritten by rs.
      mt32(32'h11, 32'h22);
      @(negedge clk); b32.start = 1'b1; b32.wr_hi = 1'b1; b32.op = OP_MULT; b32.rs = 2; b32.rt = 2;
      @(negedge clk); b32.start = 1'b0; b32.wr_hi = 1'b0;
      check("start_wins_mid", {b32.hi, b32.lo}, {32'h11, 32'h22});
      wait_idle32(cyc);
      check("start_wins_hilo", {b32.hi, b32.lo}, {32'h0, 32'h4});

      // Reset during busy cycle 3 of a DIV aborts it with no late write-back.
      mt32(32'h1, 32'h2);
      @(negedge clk); b32.start = 1'b1; b32.op = OP_DIV; b32.rs = 100; b32.rt = 7;
      @(negedge clk); b32.start = 1'b0;
      repeat (2) @(negedge clk);
      check("abort_busy_before", 64'(b32.busy), 64'(1));
      reset = 1'b1;
      @(negedge clk); reset = 1'b0;
      check("abort_busy", 64'(b32.busy), 64'(0));
      check("abort_hilo", {b32.hi, b32.lo}, 64'h0);
      repeat (15) @(negedge clk);
      check("abort_no_late_wb", {64'(b32.busy), b32.hi, b32.lo}, 64'h0);

      // 16-bit, single-cycle multiply build.
      @(negedge clk); b16.start = 1'b1; b16.op = OP_MULTU; b16.rs = 16'hFFFF; b16.rt = 16'hFFFF;
      @(negedge clk); b16.start = 1'b0;
      cyc = 0;
      while (b16.busy && cyc < 200) begin cyc++; @(negedge clk); end
      check("w16_multu_cycles", 64'(cyc), 64'(1));
      check("w16_multu_hilo", {b16.hi, b16.lo}, {16'hFFFE, 16'h0001});

      @(negedge clk); b16.start = 1'b1; b16.op = OP_DIV; b16.rs = 16'h8000; b16.rt = 16'hFFFF;
      @(negedge clk); b16.start = 1'b0;
      cyc = 0;
      while (b16.busy && cyc < 200) begin cyc++; @(negedge clk); end
      check("w16_div_cycles", 64'(cyc), 64'(10));
      check("w16_div_hilo", {b16.hi, b16.lo}, {16'h0000, 16'h8000});

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
